// File: rtl/pixel_clk_pkg.sv
// Shared types and constants for the pixel clock-enable generator.
// Increment table assumes a 100 MHz clk_in and a 32-bit accumulator.
package pixel_clk_pkg;

  localparam int MODE_W       = 2;
  localparam int DEFAULT_MODE = 1;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2,
    ST_SWITCH = 2'd3
  } state_e;

  // 25.175, 25.2, 40.0 and 74.25 MHz from 100 MHz: round(f / 100e6 * 2^32)
  localparam logic [3:0][31:0] INC_TABLE = {
    32'd3189013217, 32'd1717986918, 32'd1082331759, 32'd1081258017
  };

  // Out-of-range indices resolve to the last table entry.
  function automatic logic [31:0] inc_lookup(input logic [31:0] m);
    logic [1:0] idx;
    idx = (m > 32'd3) ? 2'd3 : m[1:0];
    return INC_TABLE[idx];
  endfunction

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator: increment mux, ACC_W-bit accumulator and registered carry.
// clr_i zeroes the accumulator but still registers the carry of the current sum.
module phase_acc
  import pixel_clk_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int MW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic [MW-1:0] mode_i,
  output logic          carry_o,
  output logic          ce_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;
  logic             ce_q;

  assign inc     = ACC_W'(inc_lookup(32'(mode_i)));
  assign sum     = {1'b0, acc_q} + {1'b0, inc};
  assign carry_o = sum[ACC_W];
  assign ce_o    = ce_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= clr_i ? '0 : sum[ACC_W-1:0];
      ce_q  <= sum[ACC_W];
    end
  end

endmodule

// File: rtl/pixel_ce_gen.sv
// Fractional-N pixel clock-enable generator with glitch-free mode switching.
// Define PIX_CE_TOGGLE_EN to get a divided pixel clock on pix_clk_div.
module pixel_ce_gen
  import pixel_clk_pkg::*;
#(
  parameter  int ACC_W         = 32,
  parameter  int NUM_MODES     = 4,
  parameter  int SETTLE_CYCLES = 256,
  localparam int MW            = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
  localparam int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic          clk_in,
  input  logic          reset_n,
  input  logic [MW-1:0] mode_sel,
  input  logic          mode_req,
  output logic          mode_ack,
  output logic [MW-1:0] mode_cur,
  output logic          pix_ce,
  output logic          locked,
  output logic          pix_clk_div
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [MW-1:0]   mode_cur_q, mode_cur_d;
  logic [MW-1:0]   mode_pend_q, mode_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic            acc_clr;
  logic            carry;

  phase_acc #(.ACC_W(ACC_W), .MW(MW)) u_acc (
    .clk_i   (clk_in),
    .rst_ni  (reset_n),
    .clr_i   (acc_clr),
    .mode_i  (mode_cur_q),
    .carry_o (carry),
    .ce_o    (pix_ce)
  );

  always_comb begin
    state_d     = state_q;
    mode_cur_d  = mode_cur_q;
    mode_pend_d = mode_pend_q;
    cnt_d       = cnt_q;
    ack_d       = 1'b0;
    acc_clr     = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
        acc_clr = 1'b1;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = ST_LOCKED;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_LOCKED: begin
        if (mode_req) begin
          state_d     = ST_SWITCH;
          ack_d       = 1'b1;
          mode_pend_d = (32'(mode_sel) >= NUM_MODES) ? MW'(NUM_MODES - 1) : mode_sel;
        end
      end
      ST_SWITCH: begin
        // Switch on a carry so the last old-rate period is complete.
        if (carry) begin
          state_d    = ST_SETTLE;
          acc_clr    = 1'b1;
          mode_cur_d = mode_pend_q;
          cnt_d      = '0;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET;
      mode_cur_q  <= MW'(DEFAULT_MODE);
      mode_pend_q <= '0;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_cur_q  <= mode_cur_d;
      mode_pend_q <= mode_pend_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
    end
  end

  assign mode_ack = ack_q;
  assign mode_cur = mode_cur_q;
  assign locked   = (state_q == ST_LOCKED);

`ifdef PIX_CE_TOGGLE_EN
  logic div_q;
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)                div_q <= 1'b0;
    else if (state_q == ST_RESET) div_q <= 1'b0;
    else if (pix_ce)             div_q <= ~div_q;
  end
  assign pix_clk_div = div_q;
`else
  assign pix_clk_div = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_ce_gen.sv
// Directed bench for pixel_ce_gen: reset/lock timing, mode switching, rates and gaps.
module tb_pixel_ce_gen;

  logic       clk_in   = 1'b0;
  logic       reset_n  = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       mode_req = 1'b0;
  logic       mode_ack, pix_ce, locked, pix_clk_div;
  logic [1:0] mode_cur;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int pce_cnt, last_ce, gmin, gmax, div_edges;
  logic div_prev = 1'b0;

  typedef struct {
    logic [1:0] mode;
    int n;
    int exp_cnt;
    int gap_lo;
    int gap_hi;
    int first_gap;
  } vec_t;
  vec_t tbl[5];

  always #5 clk_in = ~clk_in;

  pixel_ce_gen dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .mode_sel    (mode_sel),
    .mode_req    (mode_req),
    .mode_ack    (mode_ack),
    .mode_cur    (mode_cur),
    .pix_ce      (pix_ce),
    .locked      (locked),
    .pix_clk_div (pix_clk_div)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // One clock; outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
    cyc++;
    if (pix_ce) begin
      pce_cnt++;
      if (last_ce >= 0) begin
        if (cyc - last_ce < gmin) gmin = cyc - last_ce;
        if (cyc - last_ce > gmax) gmax = cyc - last_ce;
      end
      last_ce = cyc;
    end
    if (pix_clk_div !== div_prev) div_edges++;
    div_prev = pix_clk_div;
  endtask

  task automatic wait_locked(input int ref_cyc, input int exp, input string name);
    while (!locked && (cyc - ref_cyc) < exp + 50) step();
    chk(name, cyc - ref_cyc, exp);
  endtask

  task automatic do_switch(input logic [1:0] m, output int bnd);
    mode_sel = m;
    mode_req = 1'b1;
    step();
    mode_req = 1'b0;
    chk("ack_pulse", mode_ack, 1);
    chk("locked_drop", locked, 0);
    step();
    chk("ack_single", mode_ack, 0);
    bnd = -1;
    for (int i = 0; i < 16 && bnd < 0; i++) begin
      if (pix_ce) bnd = cyc;
      else        step();
    end
    chk("boundary_found", (bnd >= 0), 1);
    chk("mode_cur_at_boundary", mode_cur, m);
  endtask

  initial begin
    int first_ce;
    int bnd;
    logic mode_ok;

    tbl[0] = '{2'd2, 8000, 3200, 2, 3, 3};
    tbl[1] = '{2'd0, 8000, 2014, 3, 4, 4};
    tbl[2] = '{2'd1, 8000, 2016, 3, 4, 4};
    tbl[3] = '{2'd1, 8000, 2016, 3, 4, 4};  // same-mode re-phase
    tbl[4] = '{2'd3, 8000, 5940, 1, 2, 2};

    pce_cnt = 0; last_ce = -1; gmin = 1000; gmax = 0; div_edges = 0;

    repeat (3) step();
    chk("rst_pix_ce", pix_ce, 0);
    chk("rst_locked", locked, 0);
    chk("rst_mode_ack", mode_ack, 0);
    chk("rst_mode_cur", mode_cur, 1);
    chk("rst_pix_clk_div", pix_clk_div, 0);

    reset_n = 1'b1;
    cyc = 0;
    first_ce = -1;
    while (cyc < 100) begin
      step();
      if (pix_ce && first_ce < 0) first_ce = cyc;
    end
    chk("first_pix_ce_cycle", first_ce, 5);

    // Request while settling must be ignored.
    mode_sel = 2'd2;
    mode_req = 1'b1;
    step();
    mode_req = 1'b0;
    chk("settle_req_no_ack", mode_ack, 0);
    wait_locked(0, 257, "locked_rise_cycle");
    chk("settle_req_mode_cur", mode_cur, 1);

    for (int i = 0; i < 5; i++) begin
      do_switch(tbl[i].mode, bnd);
      step();
      while (!pix_ce && (cyc - bnd) < 10) step();
      chk("first_gap_after_switch", cyc - bnd, tbl[i].first_gap);
      wait_locked(bnd, 256, "relock_cycles");
      chk("mode_cur_locked", mode_cur, tbl[i].mode);
      pce_cnt = 0; last_ce = -1; gmin = 1000; gmax = 0; div_edges = 0;
      repeat (tbl[i].n) step();
      chk_rng("pix_ce_count", pce_cnt, tbl[i].exp_cnt - 1, tbl[i].exp_cnt + 1);
      chk_rng("gap_min", gmin, tbl[i].gap_lo, tbl[i].gap_hi);
      chk_rng("gap_max", gmax, tbl[i].gap_lo, tbl[i].gap_hi);
`ifdef PIX_CE_TOGGLE_EN
      chk_rng("div_edges", div_edges, pce_cnt - 1, pce_cnt + 1);
`else
      chk("div_edges", div_edges, 0);
`endif
    end

    // Reset in the middle of a switch from mode 3 to mode 0.
    mode_sel = 2'd0;
    mode_req = 1'b1;
    step();
    mode_req = 1'b0;
    chk("midswitch_ack", mode_ack, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_pix_ce", pix_ce, 0);
    chk("abort_locked", locked, 0);
    chk("abort_mode_ack", mode_ack, 0);
    chk("abort_mode_cur", mode_cur, 1);
    chk("abort_pix_clk_div", pix_clk_div, 0);
    repeat (2) step();
    reset_n = 1'b1;
    cyc = 0;
    mode_ok = 1'b1;
    while (!locked && cyc < 300) begin
      step();
      if (mode_cur !== 2'd1) mode_ok = 1'b0;
    end
    chk("abort_relock_cycle", cyc, 257);
    chk("abort_pending_discarded", mode_ok, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
